// File: rtl/alu_sequencer.sv
// alu_sequencer
// Sequences single-nibble commands onto an external combinational ALU and
// returns one registered response per command. It also keeps a 4-bit
// accumulator that serves as ALU operand 1.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready is 1 only in IDLE. rsp_valid stays high, with rsp_*
// frozen, until rsp_ready is seen.
//
// Optional feature: define ALU_SEQ_MUL_EN to enable cmd_op 4'b1001. This is an
// unsigned 4x4 shift-and-add multiply that runs through ALU opcode 000. When
// the macro is undefined, 1001 is an illegal command and rsp_ext reads 0.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_operand payload
//   alu_in1/alu_in2       operands to the ALU; alu_opcode selects ALU function
//   alu_out/alu_flags     ALU result and {neg, zero, ovf, carry}
//   rsp_valid/rsp_ready   response handshake
//   rsp_data/rsp_ext      result nibble / multiply high nibble
//   rsp_flags, rsp_err    {neg, zero, ovf, carry}, illegal-command marker
//   acc                   accumulator
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_operand,
    output logic [3:0] alu_in1,
    output logic [3:0] alu_in2,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_out,
    input  logic [3:0] alu_flags,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_data,
    output logic [3:0] rsp_ext,
    output logic [3:0] rsp_flags,
    output logic       rsp_err,
    output logic [3:0] acc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
`ifdef ALU_SEQ_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd2;
`endif
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [3:0] opd_q, opd_d;
    logic [3:0] acc_q, acc_d;
    logic [3:0] data_q, data_d;
    logic [3:0] flags_q, flags_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
`ifdef ALU_SEQ_MUL_EN
    logic [3:0] ext_q, ext_d;
    logic [3:0] p_hi_q, p_hi_d;
    logic [3:0] p_lo_q, p_lo_d;
    logic [1:0] cnt_q, cnt_d;
    logic [4:0] mul_sum;
`endif

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        opd_d      = opd_q;
        acc_d      = acc_q;
        data_d     = data_q;
        flags_d    = flags_q;
        err_d      = err_q;
        valid_d    = 1'b0;
        alu_in1    = acc_q;
        alu_in2    = 4'd0;
        alu_opcode = 3'd0;
`ifdef ALU_SEQ_MUL_EN
        ext_d      = ext_q;
        p_hi_d     = p_hi_q;
        p_lo_d     = p_lo_q;
        cnt_d      = cnt_q;
        mul_sum    = {1'b0, p_hi_q};
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    opd_d   = cmd_operand;
                    state_d = S_EXEC;
`ifdef ALU_SEQ_MUL_EN
                    if (cmd_op == 4'b1001) begin
                        // The multiplier (acc) sits in P_lo and is consumed LSB first.
                        state_d = S_MUL;
                        p_hi_d  = 4'd0;
                        p_lo_d  = acc_q;
                        cnt_d   = 2'd0;
                    end
`endif
                end
            end
            S_EXEC: begin
                state_d = S_RESP;
                err_d   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                ext_d   = 4'd0;
`endif
                if (!op_q[3]) begin
                    alu_in2    = opd_q;
                    alu_opcode = op_q[2:0];
                    acc_d      = alu_out;
                    data_d     = alu_out;
                    flags_d    = alu_flags;
                end else if (op_q == 4'b1000) begin
                    acc_d   = opd_q;
                    data_d  = opd_q;
                    flags_d = {opd_q[3], opd_q == 4'd0, 2'b00};
                end else if (op_q == 4'b1010) begin
                    acc_d   = 4'd0;
                    data_d  = 4'd0;
                    flags_d = 4'b0100;
                end else begin
                    // Illegal opcode: report the accumulator and leave it alone.
                    data_d  = acc_q;
                    flags_d = 4'd0;
                    err_d   = 1'b1;
                end
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
                alu_in1    = p_hi_q;
                alu_in2    = opd_q;
                alu_opcode = 3'd0;
                // mul_sum is {carry, P_hi} after the optional add. The 9-bit
                // {carry, P_hi, P_lo} then shifts right by one.
                if (p_lo_q[0]) begin
                    mul_sum = {alu_flags[0], alu_out};
                end
                p_hi_d = mul_sum[4:1];
                p_lo_d = {mul_sum[0], p_lo_q[3:1]};
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = S_RESP;
                    acc_d   = p_lo_d;
                    data_d  = p_lo_d;
                    ext_d   = p_hi_d;
                    flags_d = {p_lo_d[3], {p_hi_d, p_lo_d} == 8'd0, 1'b0, p_hi_d != 4'd0};
                    err_d   = 1'b0;
                end
            end
`endif
            S_RESP: begin
                // rsp_valid rises one cycle after RESP is entered, so a
                // rsp_ready that arrives early cannot complete the transfer.
                valid_d = 1'b1;
                if (valid_q && rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 4'd0;
            opd_q   <= 4'd0;
            acc_q   <= 4'd0;
            data_q  <= 4'd0;
            flags_q <= 4'd0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            ext_q   <= 4'd0;
            p_hi_q  <= 4'd0;
            p_lo_q  <= 4'd0;
            cnt_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            valid_q <= valid_d;
`ifdef ALU_SEQ_MUL_EN
            ext_q   <= ext_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_flags = flags_q;
    assign rsp_err   = err_q;
    assign acc       = acc_q;
`ifdef ALU_SEQ_MUL_EN
    assign rsp_ext   = ext_q;
`else
    assign rsp_ext   = 4'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer. It provides a behavioural ALU, drives commands and
// compares each response with an expected record {err, flags, ext, data, acc}
// queued when the command is accepted.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [3:0] cmd_operand = 4'd0;
    logic [3:0] alu_in1, alu_in2;
    logic [2:0] alu_opcode;
    logic [3:0] alu_out, alu_flags;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data, rsp_ext, rsp_flags;
    logic       rsp_err;
    logic [3:0] acc;

    int errors = 0;
    int checks = 0;
    logic [3:0] model_acc = 4'd0;
    logic [16:0] exp_q[$];

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    alu_sequencer dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_opcode(alu_opcode), .alu_out(alu_out),
        .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ext(rsp_ext), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .acc(acc)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: returns {neg, zero, ovf, carry, result}. Carry on subtract means no borrow.
    function automatic logic [7:0] alu_model(input logic [2:0] opc, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        logic       ovf;
        r   = 5'd0;
        ovf = 1'b0;
        case (opc)
            3'd0: begin
                r   = {1'b0, a} + {1'b0, b};
                ovf = (a[3] == b[3]) && (r[3] != a[3]);
            end
            3'd1: begin
                r   = {1'b0, a} + {1'b0, ~b} + 5'd1;
                ovf = (a[3] != b[3]) && (r[3] != a[3]);
            end
            3'd2: r = {1'b0, a & b};
            3'd3: r = {1'b0, a | b};
            3'd4: r = {1'b0, a ^ b};
            3'd5: r = {1'b0, ~a};
            3'd6: r = {a, 1'b0};
            default: r = {1'b0, b};
        endcase
        return {r[3], r[3:0] == 4'd0, ovf, r[4], r[3:0]};
    endfunction

    always_comb begin
        {alu_flags, alu_out} = alu_model(alu_opcode, alu_in1, alu_in2);
    end

    // Expected record for one command; advances model_acc.
    function automatic logic [16:0] model_cmd(input logic [3:0] op, input logic [3:0] opd);
        logic [7:0] a;
        logic [7:0] p;
        logic [3:0] d, f, e;
        logic       er;
        d = 4'd0; f = 4'd0; e = 4'd0; er = 1'b0;
        if (!op[3]) begin
            a = alu_model(op[2:0], model_acc, opd);
            d = a[3:0];
            f = a[7:4];
            model_acc = d;
        end else if (op == 4'b1000) begin
            d = opd;
            f = {opd[3], opd == 4'd0, 2'b00};
            model_acc = opd;
        end else if (op == 4'b1010) begin
            d = 4'd0;
            f = 4'b0100;
            model_acc = 4'd0;
        end else if (op == 4'b1001 && MUL_EN) begin
            p = {4'd0, model_acc} * {4'd0, opd};
            d = p[3:0];
            e = p[7:4];
            f = {p[3], p == 8'd0, 1'b0, p[7:4] != 4'd0};
            model_acc = d;
        end else begin
            d  = model_acc;
            er = 1'b1;
        end
        return {er, f, e, d, model_acc};
    endfunction

    // Driver: issues one command, checks latency and response, applies
    // backpressure for 'hold' cycles (with cmd_valid noise), then hands off.
    task automatic do_cmd(input logic [3:0] op, input logic [3:0] opd, input int hold, input bit early);
        logic [16:0] exp, got, snap;
        logic [3:0]  snap_acc;
        int lat, k;
        lat = (op == 4'b1001 && MUL_EN) ? 5 : 2;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ready_idle op=%h got=%b exp=1", op, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_operand = opd;
        @(posedge clk); #1;
        exp_q.push_back(model_cmd(op, opd));
        cmd_valid = 1'b0;
        cmd_op = 4'($urandom_range(0, 15));
        cmd_operand = 4'($urandom_range(0, 15));
        rsp_ready = early;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout op=%h got=no response exp=latency %0d", op, lat);
            rsp_ready = 1'b0;
            void'(exp_q.pop_front());
            return;
        end else if (k != lat) begin
            errors++;
            $display("FAIL rsp_latency op=%h got=%0d exp=%0d", op, k, lat);
        end
        exp = exp_q.pop_front();
        got = {rsp_err, rsp_flags, rsp_ext, rsp_data, acc};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL rsp_payload op=%h opd=%h got{err,flags,ext,data,acc}=%h exp=%h", op, opd, got, exp);
        end
        if (!early) begin
            snap = got;
            snap_acc = acc;
            for (int i = 0; i < hold; i++) begin
                cmd_valid = 1'b1;
                cmd_op = 4'($urandom_range(0, 15));
                cmd_operand = 4'($urandom_range(0, 15));
                @(posedge clk); #1;
                checks++;
                if ({rsp_err, rsp_flags, rsp_ext, rsp_data, acc} !== snap || rsp_valid !== 1'b1
                    || cmd_ready !== 1'b0 || acc !== snap_acc) begin
                    errors++;
                    $display("FAIL rsp_hold cycle=%0d got=%h v=%b cr=%b exp=%h v=1 cr=0", i,
                             {rsp_err, rsp_flags, rsp_ext, rsp_data, acc}, rsp_valid, cmd_ready, snap);
                end
            end
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL handoff_idle got cr=%b v=%b exp cr=1 v=0", cmd_ready, rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        model_acc = 4'd0;
        checks++;
        if ({cmd_ready, rsp_valid, acc, rsp_data, rsp_ext, rsp_flags, rsp_err} !== {1'b1, 1'b0, 17'd0}) begin
            errors++;
            $display("FAIL reset_state got cr=%b v=%b acc=%h d=%h e=%h f=%h err=%b exp cr=1 others 0",
                     cmd_ready, rsp_valid, acc, rsp_data, rsp_ext, rsp_flags, rsp_err);
        end
        checks++;
        if (alu_in1 !== 4'd0 || alu_in2 !== 4'd0 || alu_opcode !== 3'd0) begin
            errors++;
            $display("FAIL reset_alu got in1=%h in2=%h opc=%h exp 0,0,0", alu_in1, alu_in2, alu_opcode);
        end
    endtask

    task automatic test_add_sub();
        do_cmd(4'b1000, 4'h7, 0, 1'b0);
        do_cmd(4'b0000, 4'h3, 0, 1'b0);
        checks++;
        if (rsp_data !== 4'hA || rsp_flags !== 4'b1010 || acc !== 4'hA) begin
            errors++;
            $display("FAIL add_7_3 got d=%h f=%b acc=%h exp d=a f=1010 acc=a", rsp_data, rsp_flags, acc);
        end
        do_cmd(4'b1000, 4'h3, 0, 1'b0);
        do_cmd(4'b0001, 4'h3, 0, 1'b0);
        checks++;
        if (rsp_data !== 4'h0 || rsp_flags !== 4'b0101) begin
            errors++;
            $display("FAIL sub_3_3 got d=%h f=%b exp d=0 f=0101", rsp_data, rsp_flags);
        end
        checks++;
        if (alu_in2 !== 4'd0 || alu_opcode !== 3'd0 || alu_in1 !== acc) begin
            errors++;
            $display("FAIL idle_alu got in1=%h in2=%h opc=%h exp in1=%h in2=0 opc=0", alu_in1, alu_in2, alu_opcode, acc);
        end
    endtask

    task automatic test_mul();
        do_cmd(4'b1000, 4'hF, 0, 1'b0);
        do_cmd(4'b1001, 4'hF, 0, 1'b0);
        checks++;
        if (MUL_EN) begin
            if (rsp_data !== 4'h1 || rsp_ext !== 4'hE || rsp_flags !== 4'b0001 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL mul_f_f got d=%h e=%h f=%b err=%b exp d=1 e=e f=0001 err=0", rsp_data, rsp_ext, rsp_flags, rsp_err);
            end
        end else begin
            if (rsp_data !== 4'hF || rsp_ext !== 4'h0 || rsp_flags !== 4'b0000 || rsp_err !== 1'b1 || acc !== 4'hF) begin
                errors++;
                $display("FAIL mul_disabled got d=%h e=%h f=%b err=%b acc=%h exp d=f e=0 f=0 err=1 acc=f", rsp_data, rsp_ext, rsp_flags, rsp_err, acc);
            end
        end
        do_cmd(4'b1000, 4'h0, 0, 1'b0);
        do_cmd(4'b1001, 4'h9, 0, 1'b0);
    endtask

    task automatic test_illegal_and_clear();
        do_cmd(4'b1000, 4'h5, 0, 1'b0);
        do_cmd(4'b1011, 4'h2, 0, 1'b0);
        checks++;
        if (rsp_err !== 1'b1 || rsp_data !== 4'h5 || rsp_flags !== 4'h0 || acc !== 4'h5) begin
            errors++;
            $display("FAIL illegal_1011 got err=%b d=%h f=%h acc=%h exp err=1 d=5 f=0 acc=5", rsp_err, rsp_data, rsp_flags, acc);
        end
        do_cmd(4'b1010, 4'h9, 0, 1'b0);
        checks++;
        if (rsp_err !== 1'b0 || rsp_data !== 4'h0 || rsp_flags !== 4'b0100 || acc !== 4'h0) begin
            errors++;
            $display("FAIL clear got err=%b d=%h f=%b acc=%h exp err=0 d=0 f=0100 acc=0", rsp_err, rsp_data, rsp_flags, acc);
        end
    endtask

    task automatic test_back_to_back();
        do_cmd(4'b1000, 4'hC, 5, 1'b0);
        do_cmd(4'b0011, 4'h1, 5, 1'b0);
        do_cmd(4'b0100, 4'hF, 0, 1'b1);
        do_cmd(4'b1001, 4'h3, 3, 1'b0);
        do_cmd(4'b1001, 4'h2, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int seen;
        do_cmd(4'b1000, 4'hF, 0, 1'b0);
        cmd_valid = 1'b1; cmd_op = MUL_EN ? 4'b1001 : 4'b0000; cmd_operand = 4'hF;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (MUL_EN) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        rsp_ready = 1'b0;
        model_acc = 4'd0;
        checks++;
        if (acc !== 4'd0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got acc=%h v=%b cr=%b exp acc=0 v=0 cr=1", acc, rsp_valid, cmd_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_drop got %0d valid cycles exp 0", seen);
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            do_cmd(op, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_illegal_and_clear();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 The ports SHALL be, in order:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer accepts command
- cmd_op  in  4  command code
- cmd_operand  in  4  operand
- alu_in1  out  4  to ALU operand 1
- alu_in2  out  4  to ALU operand 2
- alu_opcode  out  3  to ALU opcode
- alu_out  in  4  ALU result (combinational from alu_*)
- alu_flags  in  4  ALU flags {neg, zero, ovf, carry}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  4  result nibble
- rsp_ext  out  4  multiply high nibble, else 0
- rsp_flags  out  4  {neg, zero, ovf, carry}
- rsp_err  out  1  illegal command
- acc  out  4  accumulator

Function
REQ-003 States SHALL be IDLE, EXEC, MUL, RESP; cmd_ready SHALL be 1 only in IDLE.
REQ-004 Transitions:
- IDLE -> MUL on cmd_valid with cmd_op=1001 (when multiply is enabled).
- IDLE -> EXEC on any other cmd_valid.
- EXEC -> RESP after one cycle.
- MUL -> RESP after four cycles.
- RESP -> IDLE on rsp_ready.
REQ-005 On acceptance, cmd_op and cmd_operand SHALL be registered; later changes on cmd_* SHALL have no effect.
REQ-006 For cmd_op 0000-0111 in EXEC, the outputs SHALL be alu_in1=acc, alu_in2=operand, alu_opcode=cmd_op[2:0].
- At the end of EXEC: acc<=alu_out, rsp_data<=alu_out, rsp_flags<=alu_flags unchanged.
REQ-007 cmd_op 1000 (load) SHALL set acc and rsp_data to the operand.
- rsp_flags SHALL be {operand[3], operand==0, 0, 0}.
REQ-008 cmd_op 1010 (clear) SHALL set acc=0, rsp_data=0, rsp_flags=4'b0100.
REQ-009 cmd_op 1011-1111 SHALL leave acc unchanged and set rsp_data=acc, rsp_flags=0, rsp_err=1.
- rsp_err SHALL be 0 for all legal commands.
REQ-010 Multiply SHALL compute unsigned acc*operand by shift-and-add, one iteration per MUL cycle, using ALU opcode 000.
- Each iteration drives alu_in1=P_hi, alu_in2=multiplicand.
- If the multiplier LSB is 1, {carry,P_hi} <= {alu_flags[0],alu_out}; the 9-bit {carry,P_hi,P_lo} SHALL then shift right one place.
REQ-011 On multiply completion: acc=P_lo, rsp_data=P_lo, rsp_ext=P_hi.
- rsp_flags = {P_lo[3], product==0, 0, P_hi!=0}.
REQ-012 Latency: a command accepted at edge N SHALL give rsp_valid=1 after edge N+2 (EXEC) or N+5 (MUL).
REQ-013 rsp_* SHALL stay stable while rsp_valid=1 and rsp_ready=0.
- cmd_valid SHALL be ignored during that time.
REQ-014 rsp_ready asserted before rsp_valid SHALL have no effect; with rsp_valid&rsp_ready, the state SHALL be IDLE on the next cycle (cmd_ready=1).
REQ-015 Outside EXEC/MUL the ALU outputs SHALL be alu_in1=acc, alu_in2=0, alu_opcode=000.

Reset
REQ-016 Reset SHALL force IDLE with acc=0, rsp_valid=0, rsp_data=0, rsp_ext=0, rsp_flags=0, rsp_err=0, cmd_ready=1 on the next cycle.
REQ-017 Reset in EXEC, MUL or RESP SHALL drop the in-flight command with no response; reset SHALL take priority over all handshakes.

Configuration
REQ-018 Macro ALU_SEQ_MUL_EN:
- Defined: cmd_op 1001 SHALL perform the multiply (REQ-010/011).
- Undefined: no MUL state or product logic; 1001 SHALL be treated as illegal (REQ-009); rsp_ext SHALL be tied to 0.

Verification
REQ-019 Load 0x7, then op 000 with 0x3 -> rsp_data=0xA, rsp_flags=4'b1010, acc=0xA, rsp_valid at N+2.
REQ-020 Load 0x3, then op 001 with 0x3 -> rsp_data=0x0, rsp_flags=4'b0101.
REQ-021 (ALU_SEQ_MUL_EN) Load 0xF, then 1001 with 0xF -> rsp_data=0x1, rsp_ext=0xE, rsp_flags=4'b0001, rsp_valid at N+5.
REQ-022 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* constant, cmd_ready=0, acc unchanged; rsp_ready=1 -> IDLE next cycle.
REQ-023 Assert reset during the 2nd MUL cycle -> next cycle: acc=0, rsp_valid=0, cmd_ready=1; no response is ever produced.
REQ-024 cmd_op 1011 with acc=0x5 -> rsp_err=1, rsp_data=0x5, rsp_flags=0, acc=0x5; without ALU_SEQ_MUL_EN, 1001 gives the same result.
